exc_commit_ctrl: RTL and testbench

Exception/interrupt commit controller between the write-back stage and the CP0 register block. It synchronises external interrupt lines into `int_num` and picks the highest-priority event on the committing instruction. It then drives the one-cycle `exc_type`/`eret` strobes into CP0, flushes the pipeline and hands a redirect PC to fetch over a valid/ready handshake.

---
 rtl/exc_commit_ctrl_if.sv | 57 +++++
 rtl/exc_commit_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_ctrl_if.sv
// exc_commit_ctrl_if
// Signal bundle around the exception/interrupt commit controller. It carries:
//   - the raw external interrupt pins and their synchronised copy for CP0
//   - the committing write-back stage (valid, pc, slot, raw exception flags, eret)
//   - the CP0 strobes and captured values (exc_type, eret, exc_pc, bad_vaddr, ...)
//   - the valid/ready redirect channel into fetch
// Modports:
//   master : the controller (exc_commit_ctrl) drives the commit-side outputs
//   slave  : write-back stage, CP0 and fetch as seen from outside the controller
interface exc_commit_ctrl_if;
   // Interrupt pins and CP0 interrupt status
   logic [4:0]  hw_int;
   logic [4:0]  int_num;
   logic        int_happen;
   logic [31:0] epc;

   // Write-back stage
   logic        ws_valid;
   logic [31:0] ws_pc;
   logic        ws_is_slot;
   logic [6:0]  ws_exc;        // {adel_fetch, ri, ov, sys, bp, adel_data, ades}
   logic [31:0] ws_data_vaddr;
   logic        ws_eret;
   logic        ws_cancel;
   logic        ws_stall;

   // CP0 commit strobes
   logic [6:0]  exc_type;      // {int, adel, ades, sys, bp, ri, ov}
   logic [31:0] exc_pc;
   logic        exc_is_slot;
   logic [31:0] bad_vaddr;
   logic        eret;

   // Pipeline flush and fetch redirect
   logic        flush;
   logic        fs_redirect_valid;
   logic [31:0] fs_redirect_pc;
   logic        fs_redirect_ready;

   modport master (
      input  hw_int, int_happen, epc,
      input  ws_valid, ws_pc, ws_is_slot, ws_exc, ws_data_vaddr, ws_eret,
      input  fs_redirect_ready,
      output int_num, ws_cancel, ws_stall,
      output exc_type, exc_pc, exc_is_slot, bad_vaddr, eret,
      output flush, fs_redirect_valid, fs_redirect_pc
   );

   modport slave (
      output hw_int, int_happen, epc,
      output ws_valid, ws_pc, ws_is_slot, ws_exc, ws_data_vaddr, ws_eret,
      output fs_redirect_ready,
      input  int_num, ws_cancel, ws_stall,
      input  exc_type, exc_pc, exc_is_slot, bad_vaddr, eret,
      input  flush, fs_redirect_valid, fs_redirect_pc
   );
endinterface

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl
// Exception/interrupt commit controller between write-back and CP0.
//   - Synchronises hw_int into int_num (two flops per bit).
//   - On a committing instruction in IDLE, picks the highest-priority event
//     (int > adel_fetch > ri > ov > sys > bp > adel_data > ades, all beating eret),
//     cancels the instruction's writes and captures pc/slot/type/bad_vaddr/target.
//   - Strobes exc_type or eret for exactly the first FLUSH cycle, holds flush for
//     FLUSH_CYCLES cycles, then offers the redirect PC to fetch over valid/ready.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset
//   bus_io : exc_commit_ctrl_if.master (write-back, CP0 and fetch signals)
// Parameters:
//   EXC_VECTOR   : exception entry PC
//   FLUSH_CYCLES : cycles flush stays high, 1..15
module exc_commit_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   exc_commit_ctrl_if.master bus_io
);

   localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

   // ws_exc bit positions
   localparam int unsigned WsAdelF = 6;
   localparam int unsigned WsRi    = 5;
   localparam int unsigned WsOv    = 4;
   localparam int unsigned WsSys   = 3;
   localparam int unsigned WsBp    = 2;
   localparam int unsigned WsAdelD = 1;
   localparam int unsigned WsAdes  = 0;

   // exc_type encodings
   localparam logic [6:0] TyInt  = 7'b1000000;
   localparam logic [6:0] TyAdel = 7'b0100000;
   localparam logic [6:0] TyAdes = 7'b0010000;
   localparam logic [6:0] TySys  = 7'b0001000;
   localparam logic [6:0] TyBp   = 7'b0000100;
   localparam logic [6:0] TyRi   = 7'b0000010;
   localparam logic [6:0] TyOv   = 7'b0000001;

   typedef enum logic [1:0] {
      StIdle,
      StFlush,
      StRedirect
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  int_sync_q, int_num_q;
   logic [6:0]  exc_type_q, exc_type_d;
   logic        eret_q, eret_d;
   logic [31:0] exc_pc_q, exc_pc_d;
   logic        exc_is_slot_q, exc_is_slot_d;
   logic [31:0] bad_vaddr_q, bad_vaddr_d;
   logic [31:0] target_q, target_d;

   logic        is_idle;
   logic        has_exc;
   logic        accept;
   logic [6:0]  type_enc;
   logic [31:0] vaddr_sel;

   // ---------------------------------------------------------------------------
   // Interrupt synchroniser
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_sync_q <= '0;
         int_num_q  <= '0;
      end else begin
         int_sync_q <= bus_io.hw_int;
         int_num_q  <= int_sync_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Event detection and priority encoding
   // ---------------------------------------------------------------------------
   assign is_idle = (state_q == StIdle);
   assign has_exc = bus_io.int_happen | (|bus_io.ws_exc);
   // An exception or interrupt turns an ERET into an ordinary excepting instruction.
   assign accept  = is_idle & bus_io.ws_valid & (has_exc | bus_io.ws_eret);

   always_comb begin
      type_enc  = '0;
      vaddr_sel = '0;
      if (bus_io.int_happen) begin
         type_enc = TyInt;
      end else if (bus_io.ws_exc[WsAdelF]) begin
         type_enc  = TyAdel;
         vaddr_sel = bus_io.ws_pc;
      end else if (bus_io.ws_exc[WsRi]) begin
         type_enc = TyRi;
      end else if (bus_io.ws_exc[WsOv]) begin
         type_enc = TyOv;
      end else if (bus_io.ws_exc[WsSys]) begin
         type_enc = TySys;
      end else if (bus_io.ws_exc[WsBp]) begin
         type_enc = TyBp;
      end else if (bus_io.ws_exc[WsAdelD]) begin
         type_enc  = TyAdel;
         vaddr_sel = bus_io.ws_data_vaddr;
      end else if (bus_io.ws_exc[WsAdes]) begin
         type_enc  = TyAdes;
         vaddr_sel = bus_io.ws_data_vaddr;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM and capture registers
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      exc_type_d    = '0;   // strobes default low: one cycle only per event
      eret_d        = 1'b0;
      exc_pc_d      = exc_pc_q;
      exc_is_slot_d = exc_is_slot_q;
      bad_vaddr_d   = bad_vaddr_q;
      target_d      = target_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d       = StFlush;
               cnt_d         = FlushInit;
               exc_type_d    = type_enc;
               eret_d        = ~has_exc;
               exc_pc_d      = bus_io.ws_pc;
               exc_is_slot_d = bus_io.ws_is_slot;
               bad_vaddr_d   = vaddr_sel;
               target_d      = has_exc ? EXC_VECTOR : bus_io.epc;
            end
         end
         StFlush: begin
            // Counter holds the number of FLUSH cycles left including this one.
            if (cnt_q <= 4'd1) begin
               state_d = StRedirect;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StRedirect: begin
            if (bus_io.fs_redirect_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         exc_type_q    <= '0;
         eret_q        <= 1'b0;
         exc_pc_q      <= '0;
         exc_is_slot_q <= 1'b0;
         bad_vaddr_q   <= '0;
         target_q      <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         exc_type_q    <= exc_type_d;
         eret_q        <= eret_d;
         exc_pc_q      <= exc_pc_d;
         exc_is_slot_q <= exc_is_slot_d;
         bad_vaddr_q   <= bad_vaddr_d;
         target_q      <= target_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus_io.int_num           = int_num_q;
   // Combinational on purpose: write-back needs it in the acceptance cycle.
   assign bus_io.ws_cancel         = is_idle & bus_io.ws_valid & has_exc;
   assign bus_io.ws_stall          = ~is_idle;
   assign bus_io.exc_type          = exc_type_q;
   assign bus_io.eret              = eret_q;
   assign bus_io.exc_pc            = exc_pc_q;
   assign bus_io.exc_is_slot       = exc_is_slot_q;
   assign bus_io.bad_vaddr         = bad_vaddr_q;
   assign bus_io.flush             = (state_q == StFlush);
   assign bus_io.fs_redirect_valid = (state_q == StRedirect);
   assign bus_io.fs_redirect_pc    = target_q;

   // ---------------------------------------------------------------------------
   // Assertions
   // ---------------------------------------------------------------------------
   a_type_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(bus_io.exc_type));

   a_no_type_and_eret : assert property (@(posedge clk) disable iff (rst)
      !(bus_io.eret && (|bus_io.exc_type)));

   a_redirect_stable : assert property (@(posedge clk) disable iff (rst)
      (bus_io.fs_redirect_valid && !bus_io.fs_redirect_ready)
         |=> (bus_io.fs_redirect_valid && $stable(bus_io.fs_redirect_pc)));

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl
// Self-checking bench for exc_commit_ctrl. Each stimulus pushes its expected commit
// (type, eret, pc, slot, bad_vaddr, redirect target) into a scoreboard queue; the
// scenario task pops it when the DUT strobes CP0 and compares inline.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_exc_commit_ctrl;

   localparam logic [31:0] VEC = 32'hbfc00380;

   localparam logic [6:0] EX_ADEL_F = 7'b1000000;
   localparam logic [6:0] EX_RI     = 7'b0100000;
   localparam logic [6:0] EX_OV     = 7'b0010000;
   localparam logic [6:0] EX_SYS    = 7'b0001000;
   localparam logic [6:0] EX_BP     = 7'b0000100;
   localparam logic [6:0] EX_ADEL_D = 7'b0000010;
   localparam logic [6:0] EX_ADES   = 7'b0000001;

   typedef struct packed {
      logic [6:0]  typ;
      logic        eret;
      logic [31:0] pc;
      logic        slot;
      logic [31:0] bva;
      logic [31:0] tgt;
   } exp_t;

   typedef struct packed {
      logic        ih;
      logic [6:0]  ex;
      logic        er;
      logic [31:0] pc;
      logic [31:0] dva;
      logic [6:0]  typ;   // exc_type the specification requires
   } stim_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t sb_q[$];

   exc_commit_ctrl_if bus ();

   exc_commit_ctrl #(
      .EXC_VECTOR  (VEC),
      .FLUSH_CYCLES(2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus_io(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   // Reference model: priority order int, then ws_exc bit 6 down to bit 0.
   function automatic exp_t model(input logic ih, input logic [6:0] ex, input logic er,
                                  input logic [31:0] pc, input logic sl,
                                  input logic [31:0] dva, input logic [31:0] ep);
      exp_t e;
      int   map [7];
      bit   found;
      map   = '{4, 5, 2, 3, 0, 1, 5};   // exc_type bit for ws_exc bit 0..6
      e     = '0;
      e.pc  = pc;
      e.slot = sl;
      found = 1'b0;
      if (ih) begin
         e.typ[6] = 1'b1;
         found    = 1'b1;
      end
      for (int i = 6; i >= 0; i--) begin
         if (!found && ex[i]) begin
            e.typ[map[i]] = 1'b1;
            found = 1'b1;
            if (i == 6) e.bva = pc;
            else if (i <= 1) e.bva = dva;
         end
      end
      e.eret = !found && er;
      e.tgt  = found ? VEC : ep;
      return e;
   endfunction

   task automatic clear_ws();
      bus.ws_valid   = 1'b0;
      bus.ws_exc     = '0;
      bus.ws_eret    = 1'b0;
      bus.int_happen = 1'b0;
      bus.ws_is_slot = 1'b0;
      bus.epc        = 32'hdeadbeef;   // proves the target was captured at acceptance
   endtask

   // Present an event at a falling edge, record the expectation, return at the
   // falling edge of the first FLUSH cycle (T+1).
   task automatic drive_event(input logic ih, input logic [6:0] ex, input logic er,
                              input logic [31:0] pc, input logic sl,
                              input logic [31:0] dva, input logic [31:0] ep,
                              input bit hold, output logic cancel);
      bus.int_happen    = ih;
      bus.ws_exc        = ex;
      bus.ws_eret       = er;
      bus.ws_pc         = pc;
      bus.ws_is_slot    = sl;
      bus.ws_data_vaddr = dva;
      bus.epc           = ep;
      bus.ws_valid      = 1'b1;
      sb_q.push_back(model(ih, ex, er, pc, sl, dva, ep));
      #1 cancel = bus.ws_cancel;
      @(posedge clk);
      @(negedge clk);
      if (!hold) clear_ws();
   endtask

   // Observe-only: find the redirect (bounded), handshake it with zero wait states.
   // lat is the cycle offset from acceptance, -1 if the redirect never came.
   task automatic wait_redirect(input int start_off, output int lat,
                                output logic [31:0] pc, output logic idle_after);
      bit seen;
      seen = 1'b0;
      lat  = -1;
      pc   = '0;
      for (int i = start_off; i < start_off + 40; i++) begin
         if (!seen) begin
            if (bus.fs_redirect_valid) begin
               seen = 1'b1;
               lat  = i;
               pc   = bus.fs_redirect_pc;
            end else begin
               @(negedge clk);
            end
         end
      end
      if (seen) begin
         bus.fs_redirect_ready = 1'b1;
         @(negedge clk);
         bus.fs_redirect_ready = 1'b0;
      end
      idle_after = !bus.ws_stall && !bus.fs_redirect_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.int_num !== 5'd0) begin failures++; $display("FAIL rst_int_num got=%h exp=0", bus.int_num); end
      checks++; if (bus.exc_type !== 7'd0) begin failures++; $display("FAIL rst_exc_type got=%h exp=0", bus.exc_type); end
      checks++; if (bus.eret !== 1'b0) begin failures++; $display("FAIL rst_eret got=%b exp=0", bus.eret); end
      checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", bus.flush); end
      checks++; if (bus.fs_redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", bus.fs_redirect_valid); end
      checks++; if (bus.fs_redirect_pc !== 32'd0) begin failures++; $display("FAIL rst_rpc got=%h exp=0", bus.fs_redirect_pc); end
      checks++; if (bus.ws_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.ws_stall); end
      checks++; if (bus.exc_pc !== 32'd0 || bus.bad_vaddr !== 32'd0) begin failures++; $display("FAIL rst_capture got=%h/%h exp=0/0", bus.exc_pc, bus.bad_vaddr); end
      // ws_cancel stays combinational while reset is held
      bus.ws_valid = 1'b1;
      bus.ws_exc   = EX_OV;
      #1;
      checks++; if (bus.ws_cancel !== 1'b1) begin failures++; $display("FAIL rst_cancel_comb got=%b exp=1", bus.ws_cancel); end
      clear_ws();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ov();
      logic c;
      exp_t e;
      drive_event(1'b0, EX_OV, 1'b0, 32'hbfc01000, 1'b0, 32'h0, 32'h0, 1'b0, c);
      e = sb_q.pop_front();
      checks++; if (c !== 1'b1) begin failures++; $display("FAIL ov_cancel got=%b exp=1", c); end
      checks++; if (bus.exc_type !== e.typ) begin failures++; $display("FAIL ov_type got=%b exp=%b", bus.exc_type, e.typ); end
      checks++; if (bus.exc_pc !== e.pc) begin failures++; $display("FAIL ov_pc got=%h exp=%h", bus.exc_pc, e.pc); end
      checks++; if (bus.eret !== e.eret) begin failures++; $display("FAIL ov_eret got=%b exp=%b", bus.eret, e.eret); end
      checks++; if (bus.flush !== 1'b1 || bus.ws_stall !== 1'b1) begin failures++; $display("FAIL ov_flush1 got=%b%b exp=11", bus.flush, bus.ws_stall); end
      @(negedge clk);   // T+2
      checks++; if (bus.exc_type !== 7'd0) begin failures++; $display("FAIL ov_type_once got=%b exp=0", bus.exc_type); end
      checks++; if (bus.flush !== 1'b1 || bus.fs_redirect_valid !== 1'b0) begin failures++; $display("FAIL ov_flush2 got=%b%b exp=10", bus.flush, bus.fs_redirect_valid); end
      @(negedge clk);   // T+3
      checks++; if (bus.flush !== 1'b0 || bus.fs_redirect_valid !== 1'b1) begin failures++; $display("FAIL ov_redir_start got=%b%b exp=01", bus.flush, bus.fs_redirect_valid); end
      checks++; if (bus.fs_redirect_pc !== e.tgt) begin failures++; $display("FAIL ov_redir_pc got=%h exp=%h", bus.fs_redirect_pc, e.tgt); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.fs_redirect_valid !== 1'b1 || bus.fs_redirect_pc !== e.tgt) begin failures++; $display("FAIL ov_redir_hold%0d got=%b/%h exp=1/%h", i, bus.fs_redirect_valid, bus.fs_redirect_pc, e.tgt); end
      end
      bus.fs_redirect_ready = 1'b1;
      @(negedge clk);
      bus.fs_redirect_ready = 1'b0;
      checks++; if (bus.fs_redirect_valid !== 1'b0 || bus.ws_stall !== 1'b0) begin failures++; $display("FAIL ov_idle got=%b%b exp=00", bus.fs_redirect_valid, bus.ws_stall); end
      checks++; if (bus.exc_pc !== e.pc) begin failures++; $display("FAIL ov_pc_held got=%h exp=%h", bus.exc_pc, e.pc); end
   endtask

   task automatic test_priority();
      stim_t tbl [8];
      logic  c, idle;
      exp_t  e;
      int    lat;
      logic [31:0] rpc;
      tbl = '{
         '{1'b1, EX_ADEL_F | EX_RI | EX_ADES, 1'b0, 32'h00400000, 32'h00000010, 7'b1000000},
         '{1'b0, EX_ADEL_F | EX_RI | EX_ADES, 1'b0, 32'h00400001, 32'h00000010, 7'b0100000},
         '{1'b0, EX_ADES,                     1'b0, 32'h00400008, 32'h00000003, 7'b0010000},
         '{1'b0, EX_ADEL_D,                   1'b0, 32'h0040000c, 32'h00001002, 7'b0100000},
         '{1'b0, EX_SYS | EX_BP,              1'b0, 32'h00400010, 32'h00000000, 7'b0001000},
         '{1'b0, EX_BP | EX_ADES,             1'b0, 32'h00400014, 32'h00000005, 7'b0000100},
         '{1'b0, EX_RI | EX_OV,               1'b1, 32'h00400018, 32'h00000000, 7'b0000010},
         '{1'b1, 7'd0,                        1'b1, 32'h0040001c, 32'h00000000, 7'b1000000}
      };
      foreach (tbl[k]) begin
         drive_event(tbl[k].ih, tbl[k].ex, tbl[k].er, tbl[k].pc, 1'b0, tbl[k].dva,
                     32'hbfc00a00, 1'b0, c);
         e = sb_q.pop_front();
         checks++; if (c !== 1'b1) begin failures++; $display("FAIL prio%0d_cancel got=%b exp=1", k, c); end
         checks++; if (bus.exc_type !== tbl[k].typ) begin failures++; $display("FAIL prio%0d_type got=%b exp=%b", k, bus.exc_type, tbl[k].typ); end
         checks++; if (bus.eret !== 1'b0) begin failures++; $display("FAIL prio%0d_eret got=%b exp=0", k, bus.eret); end
         checks++; if (bus.bad_vaddr !== e.bva) begin failures++; $display("FAIL prio%0d_bva got=%h exp=%h", k, bus.bad_vaddr, e.bva); end
         wait_redirect(1, lat, rpc, idle);
         checks++; if (lat !== 3 || rpc !== e.tgt) begin failures++; $display("FAIL prio%0d_redir got=%0d/%h exp=3/%h", k, lat, rpc, e.tgt); end
         checks++; if (idle !== 1'b1) begin failures++; $display("FAIL prio%0d_idle got=%b exp=1", k, idle); end
      end
   endtask

   task automatic test_eret();
      logic c, idle;
      exp_t e;
      int   lat;
      logic [31:0] rpc;
      drive_event(1'b0, 7'd0, 1'b1, 32'hbfc00200, 1'b0, 32'h0, 32'hbfc00a04, 1'b0, c);
      e = sb_q.pop_front();
      checks++; if (c !== 1'b0) begin failures++; $display("FAIL eret_cancel got=%b exp=0", c); end
      checks++; if (bus.eret !== 1'b1 || bus.exc_type !== 7'd0) begin failures++; $display("FAIL eret_strobe got=%b/%b exp=1/0", bus.eret, bus.exc_type); end
      @(negedge clk);
      checks++; if (bus.eret !== 1'b0) begin failures++; $display("FAIL eret_once got=%b exp=0", bus.eret); end
      wait_redirect(2, lat, rpc, idle);
      checks++; if (lat !== 3 || rpc !== e.tgt) begin failures++; $display("FAIL eret_redir got=%0d/%h exp=3/%h", lat, rpc, e.tgt); end
      // Same ERET carrying an instruction-fetch address error
      drive_event(1'b0, EX_ADEL_F, 1'b1, 32'hbfc00301, 1'b0, 32'h0, 32'hbfc00a04, 1'b0, c);
      e = sb_q.pop_front();
      checks++; if (c !== 1'b1) begin failures++; $display("FAIL eret_exc_cancel got=%b exp=1", c); end
      checks++; if (bus.eret !== 1'b0 || bus.exc_type !== e.typ) begin failures++; $display("FAIL eret_exc_strobe got=%b/%b exp=0/%b", bus.eret, bus.exc_type, e.typ); end
      checks++; if (bus.bad_vaddr !== e.bva) begin failures++; $display("FAIL eret_exc_bva got=%h exp=%h", bus.bad_vaddr, e.bva); end
      wait_redirect(1, lat, rpc, idle);
      checks++; if (rpc !== e.tgt) begin failures++; $display("FAIL eret_exc_redir got=%h exp=%h", rpc, e.tgt); end
   endtask

   task automatic test_slot_stall();
      logic c;
      exp_t e;
      // Leave the event presented through FLUSH and REDIRECT; it must be ignored.
      drive_event(1'b0, EX_SYS, 1'b0, 32'hbfc00404, 1'b1, 32'h0, 32'h0, 1'b1, c);
      e = sb_q.pop_front();
      checks++; if (bus.exc_is_slot !== e.slot || bus.exc_type !== e.typ) begin failures++; $display("FAIL slot_strobe got=%b/%b exp=%b/%b", bus.exc_is_slot, bus.exc_type, e.slot, e.typ); end
      checks++; if (bus.ws_stall !== 1'b1) begin failures++; $display("FAIL slot_stall1 got=%b exp=1", bus.ws_stall); end
      bus.ws_eret = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         @(negedge clk);
         checks++; if (bus.exc_type !== 7'd0 || bus.eret !== 1'b0) begin failures++; $display("FAIL slot_nostrobe%0d got=%b/%b exp=0/0", i, bus.exc_type, bus.eret); end
         checks++; if (bus.ws_stall !== 1'b1 || bus.ws_cancel !== 1'b0) begin failures++; $display("FAIL slot_stall%0d got=%b/%b exp=1/0", i, bus.ws_stall, bus.ws_cancel); end
      end
      clear_ws();
      checks++; if (bus.fs_redirect_valid !== 1'b1) begin failures++; $display("FAIL slot_redir got=%b exp=1", bus.fs_redirect_valid); end
      bus.fs_redirect_ready = 1'b1;
      @(negedge clk);
      bus.fs_redirect_ready = 1'b0;
      checks++; if (bus.ws_stall !== 1'b0) begin failures++; $display("FAIL slot_idle got=%b exp=0", bus.ws_stall); end
      checks++; if (bus.exc_is_slot !== 1'b1) begin failures++; $display("FAIL slot_held got=%b exp=1", bus.exc_is_slot); end
   endtask

   task automatic test_sync();
      bus.hw_int = 5'b00100;
      #1;
      checks++; if (bus.int_num !== 5'd0) begin failures++; $display("FAIL sync_e0 got=%b exp=0", bus.int_num); end
      @(negedge clk);
      checks++; if (bus.int_num !== 5'd0) begin failures++; $display("FAIL sync_e1 got=%b exp=0", bus.int_num); end
      @(negedge clk);
      checks++; if (bus.int_num !== 5'b00100) begin failures++; $display("FAIL sync_e2 got=%b exp=00100", bus.int_num); end
      bus.hw_int = 5'd0;
      repeat (3) @(negedge clk);
      checks++; if (bus.int_num !== 5'd0) begin failures++; $display("FAIL sync_clear got=%b exp=0", bus.int_num); end
   endtask

   task automatic test_back_to_back();
      logic c, idle;
      exp_t e;
      int   lat;
      logic [31:0] rpc;
      drive_event(1'b0, EX_RI, 1'b0, 32'h00800000, 1'b0, 32'h0, 32'h0, 1'b0, c);
      drive_event_pending: begin end
      e = sb_q.pop_front();
      checks++; if (bus.exc_type !== e.typ) begin failures++; $display("FAIL b2b_a_type got=%b exp=%b", bus.exc_type, e.typ); end
      wait_redirect(1, lat, rpc, idle);
      checks++; if (idle !== 1'b1 || rpc !== e.tgt) begin failures++; $display("FAIL b2b_a_redir got=%b/%h exp=1/%h", idle, rpc, e.tgt); end
      // Cycle right after the handshake
      drive_event(1'b0, EX_BP, 1'b0, 32'h00800004, 1'b1, 32'h0, 32'h0, 1'b0, c);
      e = sb_q.pop_front();
      checks++; if (c !== 1'b1) begin failures++; $display("FAIL b2b_b_cancel got=%b exp=1", c); end
      checks++; if (bus.exc_type !== e.typ || bus.exc_pc !== e.pc) begin failures++; $display("FAIL b2b_b_strobe got=%b/%h exp=%b/%h", bus.exc_type, bus.exc_pc, e.typ, e.pc); end
      wait_redirect(1, lat, rpc, idle);
      checks++; if (lat !== 3 || rpc !== e.tgt) begin failures++; $display("FAIL b2b_b_redir got=%0d/%h exp=3/%h", lat, rpc, e.tgt); end
   endtask

   task automatic test_reset_mid();
      logic c, idle;
      exp_t e;
      int   lat;
      logic [31:0] rpc;
      // Reset during the first FLUSH cycle
      drive_event(1'b0, EX_ADES, 1'b0, 32'h00900000, 1'b0, 32'h00000007, 32'h0, 1'b0, c);
      e = sb_q.pop_front();
      checks++; if (bus.exc_type !== e.typ || bus.flush !== 1'b1) begin failures++; $display("FAIL rmf_pre got=%b/%b exp=%b/1", bus.exc_type, bus.flush, e.typ); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.exc_type !== 7'd0 || bus.flush !== 1'b0 || bus.bad_vaddr !== 32'd0) begin failures++; $display("FAIL rmf_async got=%b/%b/%h exp=0/0/0", bus.exc_type, bus.flush, bus.bad_vaddr); end
      @(negedge clk);
      rst = 1'b0;
      // Reset during REDIRECT, with an interrupt line synchronised in
      bus.hw_int = 5'b10000;
      @(negedge clk);
      drive_event(1'b0, EX_OV, 1'b0, 32'h00900010, 1'b0, 32'h0, 32'h0, 1'b0, c);
      e = sb_q.pop_front();
      repeat (2) @(negedge clk);
      checks++; if (bus.fs_redirect_valid !== 1'b1 || bus.int_num !== 5'b10000) begin failures++; $display("FAIL rmr_pre got=%b/%b exp=1/10000", bus.fs_redirect_valid, bus.int_num); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.fs_redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin failures++; $display("FAIL rmr_valid got=%b/%b exp=0/0", bus.fs_redirect_valid, bus.flush); end
      checks++; if (bus.exc_type !== 7'd0 || bus.int_num !== 5'd0) begin failures++; $display("FAIL rmr_zero got=%b/%b exp=0/0", bus.exc_type, bus.int_num); end
      checks++; if (bus.fs_redirect_pc !== 32'd0 || bus.ws_stall !== 1'b0) begin failures++; $display("FAIL rmr_pc got=%h/%b exp=0/0", bus.fs_redirect_pc, bus.ws_stall); end
      bus.hw_int = 5'd0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.ws_stall !== 1'b0 || bus.fs_redirect_valid !== 1'b0) begin failures++; $display("FAIL rmr_idle got=%b/%b exp=0/0", bus.ws_stall, bus.fs_redirect_valid); end
      drive_event(1'b0, EX_OV, 1'b0, 32'h00900020, 1'b1, 32'h0, 32'h0, 1'b0, c);
      e = sb_q.pop_front();
      checks++; if (c !== 1'b1 || bus.exc_type !== e.typ || bus.exc_is_slot !== e.slot) begin failures++; $display("FAIL rmr_new got=%b/%b/%b exp=1/%b/%b", c, bus.exc_type, bus.exc_is_slot, e.typ, e.slot); end
      wait_redirect(1, lat, rpc, idle);
      checks++; if (lat !== 3 || rpc !== e.tgt || idle !== 1'b1) begin failures++; $display("FAIL rmr_new_redir got=%0d/%h/%b exp=3/%h/1", lat, rpc, idle, e.tgt); end
   endtask

   initial begin
      checks                = 0;
      failures              = 0;
      rst                   = 1'b1;
      bus.hw_int            = '0;
      bus.ws_pc             = '0;
      bus.ws_data_vaddr     = '0;
      bus.fs_redirect_ready = 1'b0;
      clear_ws();
      test_reset();
      test_ov();
      test_priority();
      test_eret();
      test_slot_stall();
      test_sync();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
